// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] inst_t;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } fetch_state_t;

  // One prefetch queue entry: 64-bit PC plus 32-bit instruction word.
  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  // Sequential successor address, wrapping modulo 2^64.
  function automatic addr_t next_pc(input addr_t pc);
    return pc + addr_t'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory port, redirect input and decode-side handshake.
interface fetch_unit_if;
  import fetch_pkg::*;

  addr_t imem_addr;
  logic  imem_req;
  inst_t imem_rdata;
  logic  br_taken;
  addr_t br_target;
  logic  inst_valid;
  logic  inst_ready;
  inst_t instruction;
  addr_t inst_pc;
  addr_t inst_pc_plus4;

  // Fetch unit side.
  modport master (
    output imem_addr, imem_req,
    input  imem_rdata,
    input  br_taken, br_target,
    output inst_valid,
    input  inst_ready,
    output instruction, inst_pc, inst_pc_plus4
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_addr, imem_req,
    output imem_rdata,
    output br_taken, br_target,
    input  inst_valid,
    output inst_ready,
    input  instruction, inst_pc, inst_pc_plus4
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instruction}, with a flush that empties it.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  fetch_entry_t     wr_data,
  input  logic             rd_en,
  output fetch_entry_t     rd_data,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  // A read only pops a real entry; a write into a full queue needs a same-cycle pop.
  assign do_rd = rd_en && (count_q != '0);
  assign do_wr = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);

  // Next-state for storage, pointers and occupancy; flush wins over everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // State registers; storage is cleared so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, single-cycle imem,
// prefetch queue toward decode, and branch redirect/flush.
// Optional build macro FETCH_STATS_EN adds the stall_cycles counter output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter addr_t       RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_t     state_q, state_d;
  addr_t            fetch_pc_q, fetch_pc_d;
  addr_t            req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] occupancy;
  logic             req_c;
  logic             wr_en;
  logic             rd_en;
  fetch_entry_t     wr_data;
  fetch_entry_t     head;

  // Queued plus in-flight entries must stay below DEPTH so a response always has a slot.
  assign occupancy = SUM_W'(fifo_count) + SUM_W'(inflight_q);
  assign req_c     = !reset && !bus.br_taken && (occupancy < SUM_W'(DEPTH));

  // Responses are captured only in RUN; the redirect cycle never has a valid one.
  assign wr_en   = inflight_q && (state_q == RUN);
  assign wr_data = '{pc: req_pc_q, inst: bus.imem_rdata};
  assign rd_en   = bus.inst_valid && bus.inst_ready;

  // Next fetch PC, in-flight tracking and redirect FSM.
  always_comb begin
    state_d    = RUN;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = req_c;
    if (bus.br_taken) begin
      state_d    = REDIR;
      fetch_pc_d = bus.br_target;
    end else if (req_c) begin
      fetch_pc_d = next_pc(fetch_pc_q);
      req_pc_d   = fetch_pc_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.br_taken),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign bus.imem_addr     = fetch_pc_q;
  assign bus.imem_req      = req_c;
  assign bus.inst_valid    = (fifo_count != '0);
  assign bus.instruction   = head.inst;
  assign bus.inst_pc       = head.pc;
  assign bus.inst_pc_plus4 = next_pc(head.pc);

`ifdef FETCH_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles with nothing to offer decode.
  always_comb begin
    stall_d = stall_q;
    if (!bus.inst_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch queue entries; power of two, at least 2.
REQ-002 Parameter RESET_PC, default 64'h0, fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  64  instruction memory fetch address.
REQ-006 imem_req  output  1  fetch issued this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid exactly one cycle after its imem_req.
REQ-008 br_taken  input  1  redirect request from the execute/PC-select stage.
REQ-009 br_target  input  64  redirect target; meaningful only when br_taken=1.
REQ-010 inst_valid  output  1  queue head holds a valid instruction.
REQ-011 inst_ready  input  1  downstream decode stage accepts the head.
REQ-012 instruction  output  32  head instruction word.
REQ-013 inst_pc  output  64  address of the head instruction.
REQ-014 inst_pc_plus4  output  64  inst_pc + 4, feeding the X30 link path.

Function
REQ-015 A handshake occurs in any cycle with inst_valid=1 and inst_ready=1; the head is dequeued on that edge.
REQ-016 imem_req=1 only when the queue count plus the in-flight count is less than DEPTH, with no redirect that cycle; the queue therefore never overflows.
REQ-017 On each issued request, fetch_pc advances by 4 modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-018 imem_addr = fetch_pc combinationally, regardless of imem_req.
REQ-019 The cycle after a request, {imem_rdata, request address} is written to the tail, unless a flush occurred in between.
REQ-020 Fetch-to-inst_valid latency from an empty queue is 2 cycles: request edge, then write edge.
REQ-021 Enqueue and dequeue in the same cycle leave the count unchanged; this also holds when the queue is full.
REQ-022 Head and tail pointers wrap modulo DEPTH.
REQ-023 When empty, inst_valid=0; instruction and inst_pc hold their last values and are don't-care.
REQ-024 br_taken=1: on that edge the queue empties, any in-flight response is discarded, and fetch_pc is set to br_target.
REQ-025 br_taken=1: no request is issued that cycle; fetch from br_target starts the next cycle.
REQ-026 A handshake in the same cycle as br_taken counts as accepted; the flush still empties the queue.
REQ-027 br_target with bits [1:0] nonzero is used as is; alignment is not checked.
REQ-028 Two-state fetch FSM:
- RUN: normal operation.
- REDIR: the single cycle after a flush; no response is captured; it always returns to RUN.
REQ-029 br_taken in REDIR re-redirects, and the later target wins.

Reset
REQ-030 Reset asserted: fetch_pc=RESET_PC, queue count=0, pointers=0, in-flight=0, FSM=RUN.
REQ-031 Reset asserted: inst_valid=0, imem_req=0, instruction=0, inst_pc=0, inst_pc_plus4=4.
REQ-032 Reset asserted mid-fetch discards the in-flight response; the first request after deassertion is to RESET_PC.

Configuration
REQ-033 Macro FETCH_STATS_EN defined: adds output stall_cycles[31:0], which increments on cycles where inst_valid=0 and reset is low, saturates at 0xFFFF_FFFF, and clears on reset.
REQ-034 Macro FETCH_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

Structure
REQ-035 Shared package fetch_pkg holds the fetch_state_t enum (RUN, REDIR), the 64-bit address typedef, and the constant INST_BYTES=4.
REQ-036 One sub-module, fetch_fifo (DEPTH x 96-bit storage, pointers, count, flush input), is instantiated once; PC and FSM logic stay in fetch_unit.

Verification
REQ-037 Reset release, inst_ready=1, imem returns 0xAAAA0000+addr: inst_pc sequence 0,4,8,..., first inst_valid 2 cycles after reset deassertion.
REQ-038 inst_ready=0 for 10 cycles with DEPTH=4: exactly 4 requests issue, imem_req then stays 0; queue holds PCs 0,4,8,12 in order.
REQ-039 br_taken=1, br_target=0x100 with 3 entries queued and 1 in flight: next cycle inst_valid=0; next accepted inst_pc=0x100; none of the old words appear.
REQ-040 RESET_PC=0xFFFF_FFFF_FFFF_FFF8: accepted PCs are ...FFF8, ...FFFC, 0x0, 0x4.
REQ-041 Back-to-back br_taken to 0x200 then 0x300: first accepted inst_pc=0x300.
REQ-042 Reset asserted for one cycle mid-stream with a full queue: inst_valid=0 immediately, and the first post-reset inst_pc=RESET_PC.
